// File: rtl/floo_wormhole_arbiter.sv
// Purpose: round-robin wormhole arbiter; once a multi-flit packet wins, the link stays with it until its last flit.
// Latency: 1 cycle from input handshake to data_o (2-entry registered output buffer), 1 flit/cycle sustained.
// Backpressure: ready_o depends only on the registered buffer count, never combinationally on ready_i.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   valid_i/ready_o/data_i/last_i   per-requester flit stream
//   valid_o/ready_i/data_o/last_o   shared output link
//   locked_o                 a multi-flit packet currently holds the link

// Purpose: generic small FIFO; storage is not reset, only pointers and count.
// Latency: data visible on out_dat the cycle after the push.
// Backpressure: pushes beyond Depth are dropped; the caller gates with count.
module floo_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 2,
    localparam int unsigned CntW  = $clog2(Depth + 1),
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_vld,
    input  T                in_dat,
    output logic            out_vld,
    input  logic            out_rdy,
    output T                out_dat,
    output logic [CntW-1:0] count
);
    T               mem [Depth];
    logic [AddrW-1:0] wr_ptr;
    logic [AddrW-1:0] rd_ptr;
    logic           push;
    logic           pop;

    assign push    = in_vld && (count < CntW'(Depth));
    assign out_vld = (count != '0);
    assign pop     = out_vld && out_rdy;
    assign out_dat = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AddrW'(Depth - 1)) ? '0 : wr_ptr + AddrW'(1);
            if (pop)  rd_ptr <= (rd_ptr == AddrW'(Depth - 1)) ? '0 : rd_ptr + AddrW'(1);
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= in_dat;
    end
endmodule

module floo_wormhole_arbiter #(
    parameter int  NumInp = 2,
    parameter type flit_t = logic [63:0],
    localparam int PtrW   = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumInp-1:0] valid_i,
    output logic [NumInp-1:0] ready_o,
    input  flit_t             data_i [NumInp],
    input  logic [NumInp-1:0] last_i,
    output logic              valid_o,
    input  logic              ready_i,
    output flit_t             data_o,
    output logic              last_o,
    output logic              locked_o
);
    typedef enum logic {IDLE, LOCKED} state_e;

    typedef struct packed {
        flit_t flit;
        logic  last;
    } ent_t;

    state_e          state;
    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] lock_idx;
    logic [PtrW-1:0] winner;
    logic [NumInp-1:0] grant;
    logic            found;
    logic            has_space;
    logic            in_hs;
    logic            sel_last;
    ent_t            push_dat;
    ent_t            pop_dat;
    logic [1:0]      fifo_cnt;

    function automatic logic [PtrW-1:0] inc_wrap(input logic [PtrW-1:0] v);
        return (v == PtrW'(NumInp - 1)) ? '0 : v + PtrW'(1);
    endfunction

    // Winner selection: locked packets keep the link, otherwise search from ptr with wrap.
    always_comb begin
        int idx;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        if (state == LOCKED) begin
            winner          = lock_idx;
            grant[lock_idx] = 1'b1;
        end else begin
            for (int k = 0; k < NumInp; k++) begin
                idx = int'(ptr) + k;
                if (idx >= NumInp) idx = idx - NumInp;
                if (!found && valid_i[idx]) begin
                    found       = 1'b1;
                    winner      = PtrW'(idx);
                    grant[idx]  = 1'b1;
                end
            end
        end
    end

    // Fullness comes from the registered count only, so no path from ready_i to ready_o.
    assign has_space = (fifo_cnt < 2'd2);
    assign ready_o   = grant & valid_i & {NumInp{has_space}};
    assign in_hs     = |ready_o;
    assign sel_last  = last_i[winner];

    assign push_dat.flit = data_i[winner];
    assign push_dat.last = sel_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            ptr      <= '0;
            lock_idx <= '0;
        end else if (in_hs) begin
            if (state == IDLE) begin
                if (sel_last) begin
                    ptr <= inc_wrap(winner);
                end else begin
                    state    <= LOCKED;
                    lock_idx <= winner;
                end
            end else if (sel_last) begin
                state <= IDLE;
                ptr   <= inc_wrap(lock_idx);
            end
        end
    end

    floo_fifo #(
        .T     (ent_t),
        .Depth (2)
    ) u_out_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .in_vld  (in_hs),
        .in_dat  (push_dat),
        .out_vld (valid_o),
        .out_rdy (ready_i),
        .out_dat (pop_dat),
        .count   (fifo_cnt)
    );

    assign data_o   = pop_dat.flit;
    assign last_o   = pop_dat.last;
    assign locked_o = (state == LOCKED);
endmodule

// File: tb/tb_floo_wormhole_arbiter.sv
// Purpose: directed checks of the wormhole arbiter with a 2-input and a 4-input instance.
// Latency: expected values are hand-derived per cycle; inputs driven 1 time unit after posedge.
// Backpressure: exercised by holding ready_i low until the output buffer fills.
module tb_floo_wormhole_arbiter;
    typedef logic [15:0] flit16_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 2-input instance
    logic [1:0] v2, r2, l2;
    flit16_t    d2 [2];
    logic       vo2, ri2, lo2, lk2;
    flit16_t    do2;

    // 4-input instance
    logic [3:0] v4, r4, l4;
    flit16_t    d4 [4];
    logic       vo4, ri4, lo4, lk4;
    flit16_t    do4;

    floo_wormhole_arbiter #(.NumInp(2), .flit_t(flit16_t)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v2), .ready_o(r2), .data_i(d2), .last_i(l2),
        .valid_o(vo2), .ready_i(ri2), .data_o(do2), .last_o(lo2), .locked_o(lk2)
    );

    floo_wormhole_arbiter #(.NumInp(4), .flit_t(flit16_t)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(v4), .ready_o(r4), .data_i(d4), .last_i(l4),
        .valid_o(vo4), .ready_i(ri4), .data_o(do4), .last_o(lo4), .locked_o(lk4)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        v2 = '0; l2 = '0; ri2 = 1'b0; d2[0] = '0; d2[1] = '0;
        v4 = '0; l4 = '0; ri4 = 1'b0;
        for (int i = 0; i < 4; i++) d4[i] = flit16_t'(16'h40 + i);
        #12;
        chk("rst_valid2",  vo2, 0);
        chk("rst_locked2", lk2, 0);
        chk("rst_ready2",  r2,  0);
        chk("rst_valid4",  vo4, 0);
        chk("rst_ready4",  r4,  0);
        rst_n = 1'b1;
        step();

        // 4 inputs: steer ptr to 3, then in1/in3 contend
        ri4 = 1'b1; l4 = '1;
        v4 = 4'b0100; #1;
        chk("rr4_in2", r4, 4'b0100);
        step();
        v4 = 4'b1010; #1;
        chk("rr4_ptr3_in3", r4, 4'b1000);
        chk("rr4_vld", vo4, 1);
        chk("rr4_dat_in2", do4, 16'h42);
        step();
        #1;
        chk("rr4_ptr0_in1", r4, 4'b0010);
        chk("rr4_dat_in3", do4, 16'h43);
        step();
        v4 = 4'b1110; #1;
        chk("rr4_ptr2_in2", r4, 4'b0100);
        chk("rr4_dat_in1", do4, 16'h41);
        step();
        v4 = '0; #1;
        chk("rr4_dat_last", do4, 16'h42);
        step();
        #1;
        chk("rr4_drained", vo4, 0);

        // 2 inputs: single-flit alternation at full rate
        ri2 = 1'b1; l2 = 2'b11; v2 = 2'b11;
        d2[0] = 16'h00A0; d2[1] = 16'h00B1;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk("alt_ready", r2, (c % 2 == 0) ? 2'b01 : 2'b10);
            if (c == 0) begin
                chk("alt_first_vld", vo2, 0);
            end else begin
                chk("alt_vld", vo2, 1);
                chk("alt_dat", do2, ((c - 1) % 2 == 0) ? 16'h00A0 : 16'h00B1);
            end
            step();
        end
        v2 = '0; #1;
        chk("alt_tail", do2, 16'h00B1);
        step();
        #1;
        chk("alt_drained", vo2, 0);

        // Locked 3-flit packet from in0 while in1 waits (ptr=0)
        v2 = 2'b11; l2 = 2'b10; d2[0] = 16'h0100; d2[1] = 16'h0200; #1;
        chk("lock_f1_rdy", r2, 2'b01);
        chk("lock_f1_lk", lk2, 0);
        step();
        d2[0] = 16'h0101; #1;
        chk("lock_f2_rdy", r2, 2'b01);
        chk("lock_f2_lk", lk2, 1);
        chk("lock_f2_dat", do2, 16'h0100);
        step();
        d2[0] = 16'h0102; l2 = 2'b11; #1;
        chk("lock_f3_rdy", r2, 2'b01);
        chk("lock_f3_lk", lk2, 1);
        chk("lock_f3_dat", do2, 16'h0101);
        step();
        d2[0] = 16'h0103; #1;
        chk("lock_in1_rdy", r2, 2'b10);
        chk("lock_unlk", lk2, 0);
        chk("lock_f3_out", do2, 16'h0102);
        chk("lock_f3_last", lo2, 1);
        step();
        v2 = 2'b01; #1;
        chk("lock_next_in0", r2, 2'b01);
        chk("lock_in1_out", do2, 16'h0200);
        step();
        v2 = '0; #1;
        chk("lock_tail", do2, 16'h0103);
        step();
        #1;
        chk("lock_drained", vo2, 0);

        // Backpressure: ptr=1, only in0 valid, ready_i low
        ri2 = 1'b0; v2 = 2'b01; l2 = 2'b11; d2[0] = 16'h0300; #1;
        chk("bp_acc0", r2, 2'b01);
        step();
        d2[0] = 16'h0301; #1;
        chk("bp_acc1", r2, 2'b01);
        chk("bp_dat0", do2, 16'h0300);
        step();
        d2[0] = 16'h0302; #1;
        chk("bp_full", r2, 2'b00);
        step();
        ri2 = 1'b1; #1;
        chk("bp_no_comb", r2, 2'b00);
        chk("bp_hold", do2, 16'h0300);
        step();
        #1;
        chk("bp_resume", r2, 2'b01);
        chk("bp_dat1", do2, 16'h0301);
        step();
        v2 = '0; #1;
        chk("bp_dat2", do2, 16'h0302);
        step();
        #1;
        chk("bp_drained", vo2, 0);

        // Reset mid-packet: ptr=1, in1 locks, two flits buffered
        ri2 = 1'b0; v2 = 2'b10; l2 = 2'b00; d2[1] = 16'h0400; #1;
        chk("rm_f1", r2, 2'b10);
        step();
        d2[1] = 16'h0401; #1;
        chk("rm_f2", r2, 2'b10);
        step();
        #1;
        chk("rm_pre_vld", vo2, 1);
        chk("rm_pre_lk", lk2, 1);
        v2 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rm_vld", vo2, 0);
        chk("rm_lk", lk2, 0);
        chk("rm_rdy", r2, 2'b00);
        step();
        rst_n = 1'b1;
        step();
        v2 = 2'b11; l2 = 2'b11; #1;
        chk("rm_ptr0", r2, 2'b01);
        chk("rm_empty", vo2, 0);
        step();
        v2 = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
